// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package if_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

    // Fetch sequencer states (3-bit encoding)
    typedef enum logic [2:0] {
        ST_BOOT = 3'd0,
        ST_REQ  = 3'd1,
        ST_HOLD = 3'd2,
        ST_DROP = 3'd3,
        ST_EXC  = 3'd4
    } fetch_state_e;

    // One fetched instruction together with the PC it came from
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_ent_t;

    // Memory is word-addressed; the low two bits never reach the bus
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_hold_buf.sv
// One-entry {pc, inst} skid buffer used when decode stalls on a returning fetch.
// Latency: loaded entry visible the cycle after load; drain/clear empty it next cycle.
// Backpressure: none internally; the sequencer stops requesting while it is full.
module if_hold_buf
    import if_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       drain,
    input  logic       clear,
    input  fetch_ent_t load_ent,
    output logic       vld,
    output fetch_ent_t ent
);

    logic       vld_q, vld_d;
    fetch_ent_t ent_q, ent_d;

    // Clear beats load beats drain; load and drain never coincide in practice
    always_comb begin
        vld_d = vld_q;
        ent_d = ent_q;
        if (clear) begin
            vld_d = 1'b0;
            ent_d = '0;
        end else if (load) begin
            vld_d = 1'b1;
            ent_d = load_ent;
        end else if (drain) begin
            vld_d = 1'b0;
        end
    end

    // Buffer state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            ent_q <= '0;
        end else begin
            vld_q <= vld_d;
            ent_q <= ent_d;
        end
    end

    assign vld = vld_q;
    assign ent = ent_q;

endmodule

// File: rtl/if_stage.sv
// Fetch PC register and single-outstanding imem request sequencer feeding decode.
// Latency: imem_ack in cycle N presents the instruction (id_valid) in cycle N+1.
// Backpressure: a fetch returning while decode stalls parks in a 1-entry hold buffer; no new request until it drains.
// Optional IF_ALIGN_CHECK_EN: misaligned PC raises id_exc instead of fetching (default: address force-aligned, id_exc = 0).
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] npc,
    output logic [31:0] pc,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_exc
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  tgt_q, tgt_d;
    logic         id_valid_q, id_valid_d;
    logic [31:0]  id_pc_q, id_pc_d;
    logic [31:0]  id_inst_q, id_inst_d;
`ifdef IF_ALIGN_CHECK_EN
    logic         id_exc_q, id_exc_d;
`endif

    logic         hb_load, hb_drain, hb_clear, hb_vld;
    fetch_ent_t   hb_in, hb_out;
    logic         req_ok;
    logic         out_free;

`ifdef IF_ALIGN_CHECK_EN
    assign req_ok = (pc_q[1:0] == 2'b00);
`else
    assign req_ok = 1'b1;
`endif

    // DROP keeps the stale request alive at the old pc until its ack retires it
    assign imem_req  = ((state_q == ST_REQ) && req_ok) || (state_q == ST_DROP);
    assign imem_addr = word_align(pc_q);
    assign out_free  = !id_valid_q || id_ready;
    assign hb_in     = '{pc: pc_q, inst: imem_rdata};

    if_hold_buf u_hold_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (hb_load),
        .drain    (hb_drain),
        .clear    (hb_clear),
        .load_ent (hb_in),
        .vld      (hb_vld),
        .ent      (hb_out)
    );

    // Next-state: flush first, then the per-state fetch/handshake rules
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        tgt_d      = tgt_q;
        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
`ifdef IF_ALIGN_CHECK_EN
        id_exc_d   = id_exc_q;
`endif
        hb_load    = 1'b0;
        hb_drain   = 1'b0;
        hb_clear   = 1'b0;

        // Decode consumed the presented entry; later loads below override this
        if (id_valid_q && id_ready) begin
            id_valid_d = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
            id_exc_d   = 1'b0;
`endif
        end

        if (flush) begin
            id_valid_d = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
            id_exc_d   = 1'b0;
`endif
            hb_clear   = 1'b0 | 1'b1;
            case (state_q)
                ST_REQ: begin
                    if (imem_req && !imem_ack) begin
                        tgt_d   = npc;
                        state_d = ST_DROP;
                    end else begin
                        pc_d    = npc;
                        state_d = ST_REQ;
                    end
                end
                ST_DROP: begin
                    // An ack in the same cycle retires the stale request, so fetch can restart now
                    if (imem_ack) begin
                        pc_d    = npc;
                        state_d = ST_REQ;
                    end else begin
                        tgt_d   = npc;
                    end
                end
                default: begin
                    pc_d    = npc;
                    state_d = ST_REQ;
                end
            endcase
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_d = ST_REQ;
                end
                ST_REQ: begin
`ifdef IF_ALIGN_CHECK_EN
                    if (!req_ok) begin
                        // Wait for a free output slot, then report the fault instead of fetching
                        if (out_free) begin
                            id_valid_d = 1'b1;
                            id_pc_d    = pc_q;
                            id_inst_d  = NOP_WORD;
                            id_exc_d   = 1'b1;
                            state_d    = ST_EXC;
                        end
                    end else
`endif
                    if (imem_ack) begin
                        pc_d = npc;
                        if (out_free) begin
                            id_valid_d = 1'b1;
                            id_pc_d    = pc_q;
                            id_inst_d  = imem_rdata;
`ifdef IF_ALIGN_CHECK_EN
                            id_exc_d   = 1'b0;
`endif
                        end else begin
                            hb_load = 1'b1;
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (id_ready && hb_vld) begin
                        id_valid_d = 1'b1;
                        id_pc_d    = hb_out.pc;
                        id_inst_d  = hb_out.inst;
`ifdef IF_ALIGN_CHECK_EN
                        id_exc_d   = 1'b0;
`endif
                        hb_drain   = 1'b1;
                        state_d    = ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (imem_ack) begin
                        pc_d    = tgt_q;
                        state_d = ST_REQ;
                    end
                end
                default: begin
                    // EXC idles until a flush redirects fetch
                    state_d = state_q;
                end
            endcase
        end
    end

    // Sequencer, PC and decode-side output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            tgt_q      <= '0;
            id_valid_q <= 1'b0;
            id_pc_q    <= '0;
            id_inst_q  <= '0;
`ifdef IF_ALIGN_CHECK_EN
            id_exc_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            tgt_q      <= tgt_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
`ifdef IF_ALIGN_CHECK_EN
            id_exc_q   <= id_exc_d;
`endif
        end
    end

    assign pc       = pc_q;
    assign id_valid = id_valid_q;
    assign id_pc    = id_pc_q;
    assign id_inst  = id_inst_q;
`ifdef IF_ALIGN_CHECK_EN
    assign id_exc   = id_exc_q;
`else
    assign id_exc   = 1'b0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus a randomized stream
// compared against an in-order fetch model (pc advances by 4, jumps on flush).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] npc;
    logic [31:0] pc;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_exc;

    int checks = 0;
    int failures = 0;

    logic        npc_ovr_en;
    logic [31:0] npc_ovr;
    int          mem_lat_fix;
    bit          mem_rand;
    int          wcnt;
    int          cur_lat;

    always #5 clk = ~clk;

    // Next-PC mux stand-in: sequential +4 unless a redirect target is forced
    assign npc = npc_ovr_en ? npc_ovr : pc + 32'd4;

    if_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .npc        (npc),
        .pc         (pc),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_pc      (id_pc),
        .id_inst    (id_inst),
        .id_exc     (id_exc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ((a >> 2) + 32'd1) * 32'h11;
    endfunction

    // Memory model: acks in the cur_lat-th cycle a request has been held
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        wcnt       = 0;
        cur_lat    = 1;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && imem_req === 1'b1 && (wcnt + 1 >= cur_lat)) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = 32'hDEAD_BEEF;
            end
            @(negedge clk);
            if (!rst_n || imem_req !== 1'b1) begin
                wcnt    = 0;
                cur_lat = mem_rand ? int'($urandom_range(1, 4)) : mem_lat_fix;
            end else if (imem_ack) begin
                wcnt    = 0;
                cur_lat = mem_rand ? int'($urandom_range(1, 4)) : mem_lat_fix;
            end else begin
                wcnt++;
            end
        end
    end

    task automatic do_reset(input int lat, input logic rdy);
        @(negedge clk);
        rst_n       = 1'b0;
        flush       = 1'b0;
        npc_ovr_en  = 1'b0;
        npc_ovr     = 32'h0;
        id_ready    = rdy;
        mem_rand    = 1'b0;
        mem_lat_fix = lat;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; flush = 1'b0; npc_ovr_en = 1'b0; npc_ovr = 32'h0;
        id_ready = 1'b1; mem_rand = 1'b0; mem_lat_fix = 1;
        @(negedge clk);
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
        checks++; if ({id_valid, id_exc} !== 2'b00) begin failures++; $display("FAIL reset_valid_exc: got %b want 00", {id_valid, id_exc}); end
        checks++; if ({id_pc, id_inst} !== 64'h0) begin failures++; $display("FAIL reset_id_regs: got %h want 0", {id_pc, id_inst}); end
        rst_n = 1'b1;
        // Reset asserted mid-stream must act immediately, without a clock edge
        do_reset(1, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL midreset_pre_valid: got %b want 1", id_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if ({imem_req, id_valid} !== 2'b00) begin failures++; $display("FAIL midreset_async: got req/valid %b want 00", {imem_req, id_valid}); end
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL midreset_pc: got %h want 0", pc); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_boot_stream();
        logic [31:0] exp_pc;
        do_reset(1, 1'b1);
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL boot_idle_req: got %b want 0", imem_req); end
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL boot_first_req: got req %b addr %h want 1 / 0", imem_req, imem_addr); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            exp_pc = 32'(i) * 32'd4;
            checks++;
            if (id_valid !== 1'b1 || id_pc !== exp_pc || id_inst !== 32'h11 * 32'(i + 1)) begin
                failures++;
                $display("FAIL boot_stream_%0d: got v %b pc %h inst %h want 1 %h %h", i, id_valid, id_pc, id_inst, exp_pc, 32'h11 * 32'(i + 1));
            end
        end
    endtask

    task automatic test_hold();
        int n;
        do_reset(1, 1'b1);
        n = 0;
        while (!(imem_req === 1'b1 && imem_addr === 32'h10) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n >= 20) begin failures++; $display("FAIL hold_reach_0x10: got timeout want request at 0x10"); end
        id_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b0 || id_valid !== 1'b1 || id_pc !== 32'hC || id_inst !== mem_word(32'hC) || pc !== 32'h14) begin
                failures++;
                $display("FAIL hold_stall_%0d: got req %b v %b id_pc %h inst %h pc %h want 0 1 c %h 14", k, imem_req, id_valid, id_pc, id_inst, mem_word(32'hC), pc);
            end
            if (k == 2) id_ready = 1'b1;
        end
        @(negedge clk);
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h10 || id_inst !== mem_word(32'h10)) begin
            failures++;
            $display("FAIL hold_release_data: got v %b pc %h inst %h want 1 10 %h", id_valid, id_pc, id_inst, mem_word(32'h10));
        end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin failures++; $display("FAIL hold_next_req: got req %b addr %h want 1 14", imem_req, imem_addr); end
    endtask

    task automatic test_flush_wait();
        do_reset(3, 1'b1);
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL fw_first_req: got %b %h want 1 0", imem_req, imem_addr); end
        flush = 1'b1; npc_ovr_en = 1'b1; npc_ovr = 32'h80;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            flush = 1'b0; npc_ovr_en = 1'b0;
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h0 || id_valid !== 1'b0) begin
                failures++;
                $display("FAIL fw_drop_%0d: got req %b addr %h v %b want 1 0 0", k, imem_req, imem_addr, id_valid);
            end
        end
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin failures++; $display("FAIL fw_target_req: got %b %h want 1 80", imem_req, imem_addr); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL fw_no_stale_%0d: got v %b pc %h want 0", k, id_valid, id_pc); end
        end
        @(negedge clk);
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h80 || id_inst !== mem_word(32'h80)) begin
            failures++;
            $display("FAIL fw_target_data: got v %b pc %h inst %h want 1 80 %h", id_valid, id_pc, id_inst, mem_word(32'h80));
        end
    endtask

    task automatic test_flush_ack();
        int n;
        do_reset(1, 1'b1);
        n = 0;
        while (!(imem_req === 1'b1 && imem_addr === 32'h8) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n >= 20) begin failures++; $display("FAIL fa_reach_0x8: got timeout want request at 0x8"); end
        flush = 1'b1; npc_ovr_en = 1'b1; npc_ovr = 32'h40;
        @(negedge clk);
        flush = 1'b0; npc_ovr_en = 1'b0;
        checks++;
        if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            failures++;
            $display("FAIL fa_after_flush: got v %b req %b addr %h want 0 1 40", id_valid, imem_req, imem_addr);
        end
        @(negedge clk);
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_inst !== mem_word(32'h40)) begin
            failures++;
            $display("FAIL fa_target_data: got v %b pc %h inst %h want 1 40 %h", id_valid, id_pc, id_inst, mem_word(32'h40));
        end
    endtask

    task automatic test_double_flush();
        int n;
        do_reset(4, 1'b1);
        @(negedge clk);
        flush = 1'b1; npc_ovr_en = 1'b1; npc_ovr = 32'h100;
        @(negedge clk);
        npc_ovr = 32'h200;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL df_drop1: got %b %h want 1 0", imem_req, imem_addr); end
        @(negedge clk);
        flush = 1'b0; npc_ovr_en = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL df_drop2: got %b %h want 1 0", imem_req, imem_addr); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin failures++; $display("FAIL df_resume_req: got %b %h want 1 200", imem_req, imem_addr); end
        n = 0;
        while (id_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h200 || id_inst !== mem_word(32'h200)) begin
            failures++;
            $display("FAIL df_first_data: got v %b pc %h inst %h want 1 200 %h", id_valid, id_pc, id_inst, mem_word(32'h200));
        end
    endtask

    task automatic test_align();
`ifdef IF_ALIGN_CHECK_EN
        do_reset(1, 1'b0);
        flush = 1'b1; npc_ovr_en = 1'b1; npc_ovr = 32'h6;
        @(negedge clk);
        flush = 1'b0; npc_ovr_en = 1'b0;
        checks++; if (pc !== 32'h6 || imem_req !== 1'b0 || id_valid !== 1'b0) begin failures++; $display("FAIL al_no_req: got pc %h req %b v %b want 6 0 0", pc, imem_req, id_valid); end
        @(negedge clk);
        checks++;
        if (id_valid !== 1'b1 || id_exc !== 1'b1 || id_pc !== 32'h6 || id_inst !== 32'h0 || imem_req !== 1'b0) begin
            failures++;
            $display("FAIL al_exc: got v %b exc %b pc %h inst %h req %b want 1 1 6 0 0", id_valid, id_exc, id_pc, id_inst, imem_req);
        end
        repeat (2) @(negedge clk);
        checks++; if (imem_req !== 1'b0 || pc !== 32'h6) begin failures++; $display("FAIL al_idle: got req %b pc %h want 0 6", imem_req, pc); end
        id_ready = 1'b1;
        @(negedge clk);
        checks++; if (id_valid !== 1'b0 || id_exc !== 1'b0) begin failures++; $display("FAIL al_consumed: got v %b exc %b want 0 0", id_valid, id_exc); end
        flush = 1'b1; npc_ovr_en = 1'b1; npc_ovr = 32'h8;
        @(negedge clk);
        flush = 1'b0; npc_ovr_en = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin failures++; $display("FAIL al_resume_req: got %b %h want 1 8", imem_req, imem_addr); end
        @(negedge clk);
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h8 || id_exc !== 1'b0) begin
            failures++;
            $display("FAIL al_resume_data: got v %b pc %h exc %b want 1 8 0", id_valid, id_pc, id_exc);
        end
`else
        do_reset(1, 1'b1);
        flush = 1'b1; npc_ovr_en = 1'b1; npc_ovr = 32'h6;
        @(negedge clk);
        flush = 1'b0; npc_ovr_en = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin failures++; $display("FAIL al_forced_addr: got %b %h want 1 4", imem_req, imem_addr); end
        @(negedge clk);
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h6 || id_inst !== mem_word(32'h4) || id_exc !== 1'b0) begin
            failures++;
            $display("FAIL al_forced_data: got v %b pc %h inst %h exc %b want 1 6 %h 0", id_valid, id_pc, id_inst, id_exc, mem_word(32'h4));
        end
        checks++; if (imem_addr !== 32'h8) begin failures++; $display("FAIL al_forced_next: got %h want 8", imem_addr); end
`endif
    endtask

    // Random latency, stalls and redirects; decode must see the in-order stream
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] prev_addr;
        logic        prev_req, prev_ack, flush_prev;
        int          hs;
        do_reset(1, 1'b1);
        mem_rand   = 1'b1;
        exp_pc     = 32'h0;
        prev_req   = 1'b0;
        prev_ack   = 1'b0;
        prev_addr  = 32'h0;
        flush_prev = 1'b0;
        hs         = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (prev_req && !prev_ack) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
                    failures++;
                    $display("FAIL rnd_req_stable cyc %0d: got req %b addr %h want 1 %h", cyc, imem_req, imem_addr, prev_addr);
                end
            end
            if (flush_prev) begin
                checks++;
                if (id_valid !== 1'b0) begin failures++; $display("FAIL rnd_flush_valid cyc %0d: got %b want 0", cyc, id_valid); end
            end
            flush = ($urandom_range(0, 99) < 3);
            npc_ovr_en = flush;
            npc_ovr = $urandom_range(0, 1023) << 2;
            id_ready = ($urandom_range(0, 99) < 70);
            if (id_valid === 1'b1 && id_ready) begin
                checks++;
                if (id_pc !== exp_pc || id_inst !== mem_word(exp_pc) || id_exc !== 1'b0) begin
                    failures++;
                    $display("FAIL rnd_stream cyc %0d: got pc %h inst %h exc %b want %h %h 0", cyc, id_pc, id_inst, id_exc, exp_pc, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                hs++;
            end
            if (flush) exp_pc = npc_ovr;
            prev_req   = imem_req;
            prev_ack   = imem_ack;
            prev_addr  = imem_addr;
            flush_prev = flush;
        end
        flush = 1'b0;
        npc_ovr_en = 1'b0;
        checks++;
        if (hs < 300) begin failures++; $display("FAIL rnd_progress: got %0d handshakes want at least 300", hs); end
    endtask

    initial begin
        flush       = 1'b0;
        id_ready    = 1'b1;
        npc_ovr_en  = 1'b0;
        npc_ovr     = 32'h0;
        mem_rand    = 1'b0;
        mem_lat_fix = 1;
        test_reset();
        test_boot_stream();
        test_hold();
        test_flush_wait();
        test_flush_ack();
        test_double_flush();
        test_align();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
